// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load opcode encodings,
// FSM state encoding and small helpers.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    OP_LW      = 3'b000,
    OP_LB      = 3'b001,
    OP_LBU     = 3'b010,
    OP_LH      = 3'b011,
    OP_LHU     = 3'b100,
    OP_LWL     = 3'b101,
    OP_LWR     = 3'b110,
    OP_NONLOAD = 3'b111
  } ms_op_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_COMMIT    = 2'd2
  } wb_state_e;

  localparam logic [3:0] STRB_ALL = 4'b1111;

  // LWL/LWR merge with the old register value, so their data is never forwardable.
  function automatic logic is_partial_word(input ms_op_e op);
    return (op == OP_LWL) || (op == OP_LWR);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data alignment: byte/halfword select and extension,
// plus LWL/LWR shifting and per-byte write strobes.
module load_align
  import wb_stage_pkg::*;
(
  input  ms_op_e      op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  strb_o,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    strb_o = STRB_ALL;
    data_o = rdata_i;
    case (op_i)
      OP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: data_o = {24'd0, byte_sel};
      OP_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU: data_o = {16'd0, half_sel};
      // ~addr_lo == 3-addr_lo, so these shift by 8*(3-addr_lo)
      OP_LWL: begin
        data_o = rdata_i << {~addr_lo_i, 3'b000};
        strb_o = STRB_ALL << ~addr_lo_i;
      end
      OP_LWR: begin
        data_o = rdata_i >> {addr_lo_i, 3'b000};
        strb_o = STRB_ALL >> addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction, waits for load data when needed,
// and commits aligned per-byte GPR writes with forwarding information.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_valid,
  output logic        ms_ready,
  input  logic [31:0] ms_pc,
  input  logic [2:0]  ms_op,
  input  logic [1:0]  ms_addr_lo,
  input  logic        ms_gpr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic [31:0] dm_rdata,
  input  logic        dm_rvalid,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_dest,
  output logic        fwd_data_ok,
  output logic [31:0] fwd_data,
  output logic [31:0] wb_pc
);

  wb_state_e   state_q;
  logic [31:0] pc_q;
  ms_op_e      op_q;
  logic [1:0]  addr_lo_q;
  logic        gpr_we_q;
  logic [4:0]  dest_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;

  logic [3:0]  align_strb;
  logic [31:0] align_data;

  load_align u_load_align (
    .op_i      (op_q),
    .addr_lo_i (addr_lo_q),
    .rdata_i   (dm_rdata),
    .strb_o    (align_strb),
    .data_o    (align_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      op_q      <= OP_NONLOAD;
      addr_lo_q <= '0;
      gpr_we_q  <= 1'b0;
      dest_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      case (state_q)
        S_WAIT_DATA: begin
          if (dm_rvalid) begin
            data_q  <= align_data;
            strb_q  <= align_strb;
            state_q <= S_COMMIT;
          end
        end
        default: begin
          // IDLE and COMMIT both accept; dm_rvalid is ignored here.
          if (ms_valid) begin
            pc_q      <= ms_pc;
            op_q      <= ms_op_e'(ms_op);
            addr_lo_q <= ms_addr_lo;
            gpr_we_q  <= ms_gpr_we;
            dest_q    <= ms_dest;
            if (ms_op_e'(ms_op) == OP_NONLOAD) begin
              data_q  <= ms_result;
              strb_q  <= STRB_ALL;
              state_q <= S_COMMIT;
            end else begin
              state_q <= S_WAIT_DATA;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  logic writes_gpr;
  logic in_commit;

  // Gating with reset suppresses a write in a COMMIT cycle that is being reset.
  assign writes_gpr  = gpr_we_q && (dest_q != '0);
  assign in_commit   = (state_q == S_COMMIT) && !reset;

  assign ms_ready    = (state_q != S_WAIT_DATA);
  assign rf_we       = (in_commit && writes_gpr) ? strb_q : '0;
  assign rf_waddr    = reset ? '0 : dest_q;
  assign rf_wdata    = reset ? '0 : data_q;
  assign wb_pc       = reset ? '0 : pc_q;
  assign fwd_valid   = !reset && (state_q != S_IDLE) && writes_gpr;
  assign fwd_dest    = reset ? '0 : dest_q;
  assign fwd_data_ok = in_commit && !is_partial_word(op_q);
  assign fwd_data    = reset ? '0 : data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// instruction streams checked against a behavioural load model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_valid;
  logic        ms_ready;
  logic [31:0] ms_pc;
  logic [2:0]  ms_op;
  logic [1:0]  ms_addr_lo;
  logic        ms_gpr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic [31:0] dm_rdata;
  logic        dm_rvalid;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic        fwd_data_ok;
  logic [31:0] fwd_data;
  logic [31:0] wb_pc;

  int checks = 0;
  int failures = 0;

  wb_stage dut (
    .clk         (clk),
    .reset       (reset),
    .ms_valid    (ms_valid),
    .ms_ready    (ms_ready),
    .ms_pc       (ms_pc),
    .ms_op       (ms_op),
    .ms_addr_lo  (ms_addr_lo),
    .ms_gpr_we   (ms_gpr_we),
    .ms_dest     (ms_dest),
    .ms_result   (ms_result),
    .dm_rdata    (dm_rdata),
    .dm_rvalid   (dm_rvalid),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_valid   (fwd_valid),
    .fwd_dest    (fwd_dest),
    .fwd_data_ok (fwd_data_ok),
    .fwd_data    (fwd_data),
    .wb_pc       (wb_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: returns {strobes, data} from the architectural load rules.
  function automatic logic [35:0] model(input logic [2:0] op, input logic [1:0] a,
                                        input logic [31:0] rd, input logic [31:0] res);
    logic [31:0] b, h, d;
    logic [3:0]  we;
    int unsigned ai;
    ai = a;
    b  = (rd >> (8 * ai)) & 32'hFF;
    h  = (rd >> (16 * (ai / 2))) & 32'hFFFF;
    we = 4'b1111;
    case (op)
      3'd0: d = rd;
      3'd1: d = (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd2: d = b;
      3'd3: d = (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4: d = h;
      3'd5: begin
        d = rd << (8 * (3 - ai));
        for (int i = 0; i < 4; i++) we[i] = (i >= 3 - int'(ai));
      end
      3'd6: begin
        d = rd >> (8 * ai);
        for (int i = 0; i < 4; i++) we[i] = (i <= 3 - int'(ai));
      end
      default: d = res;
    endcase
    return {we, d};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [1:0] a, input logic [4:0] dest,
                       input logic gwe, input logic [31:0] pc, input logic [31:0] res);
    ms_valid = 1'b1; ms_op = op; ms_addr_lo = a; ms_dest = dest;
    ms_gpr_we = gwe; ms_pc = pc; ms_result = res;
  endtask

  task automatic test_reset;
    reset = 1'b1; ms_valid = 1'b0; ms_pc = '0; ms_op = 3'd7; ms_addr_lo = '0;
    ms_gpr_we = 1'b0; ms_dest = '0; ms_result = '0; dm_rdata = '0; dm_rvalid = 1'b0;
    step; step;
    checks++; if (rf_we !== 4'b0) begin failures++; $display("FAIL rst_rf_we got=%b exp=0000", rf_we); end
    checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL rst_fwd_valid got=%b exp=0", fwd_valid); end
    checks++; if (fwd_data_ok !== 1'b0) begin failures++; $display("FAIL rst_fwd_ok got=%b exp=0", fwd_data_ok); end
    checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL rst_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", rf_wdata); end
    checks++; if (fwd_data !== 32'd0) begin failures++; $display("FAIL rst_fwd_data got=%h exp=0", fwd_data); end
    checks++; if (wb_pc !== 32'd0) begin failures++; $display("FAIL rst_wb_pc got=%h exp=0", wb_pc); end
    reset = 1'b0;
    step;
    checks++; if (ms_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ms_ready); end
    checks++; if (rf_we !== 4'b0) begin failures++; $display("FAIL idle_rf_we got=%b exp=0000", rf_we); end
  endtask

  task automatic test_alu;
    drive(3'd7, 2'd0, 5'd5, 1'b1, 32'h0000_1000, 32'h1234_5678);
    step;
    ms_valid = 1'b0;
    checks++; if (rf_we !== 4'b1111) begin failures++; $display("FAIL alu_rf_we got=%b exp=1111", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL alu_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h1234_5678) begin failures++; $display("FAIL alu_wdata got=%h exp=12345678", rf_wdata); end
    checks++; if (fwd_data_ok !== 1'b1) begin failures++; $display("FAIL alu_fwd_ok got=%b exp=1", fwd_data_ok); end
    checks++; if (fwd_data !== 32'h1234_5678) begin failures++; $display("FAIL alu_fwd_data got=%h exp=12345678", fwd_data); end
    checks++; if (fwd_valid !== 1'b1 || fwd_dest !== 5'd5) begin failures++; $display("FAIL alu_fwd got=%b/%0d exp=1/5", fwd_valid, fwd_dest); end
    checks++; if (wb_pc !== 32'h0000_1000) begin failures++; $display("FAIL alu_pc got=%h exp=00001000", wb_pc); end
    step;
    checks++; if (rf_we !== 4'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL alu_after got=%b/%b exp=0000/0", rf_we, fwd_valid); end
  endtask

  task automatic test_lb;
    drive(3'd1, 2'd2, 5'd7, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
    step;
    ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ms_ready !== 1'b0) begin failures++; $display("FAIL lb_wait_ready cyc=%0d got=%b exp=0", i, ms_ready); end
      checks++; if (rf_we !== 4'b0) begin failures++; $display("FAIL lb_wait_we cyc=%0d got=%b exp=0000", i, rf_we); end
      checks++; if (fwd_valid !== 1'b1 || fwd_data_ok !== 1'b0) begin failures++; $display("FAIL lb_wait_fwd cyc=%0d got=%b/%b exp=1/0", i, fwd_valid, fwd_data_ok); end
      dm_rdata = (i == 2) ? 32'h0080_FF00 : 32'h1111_1111;
      dm_rvalid = (i == 2);
      step;
    end
    dm_rvalid = 1'b0;
    checks++; if (rf_we !== 4'b1111) begin failures++; $display("FAIL lb_rf_we got=%b exp=1111", rf_we); end
    checks++; if (rf_wdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_wdata got=%h exp=ffffff80", rf_wdata); end
    checks++; if (rf_waddr !== 5'd7 || wb_pc !== 32'h0000_2000) begin failures++; $display("FAIL lb_addr_pc got=%0d/%h exp=7/00002000", rf_waddr, wb_pc); end
    checks++; if (fwd_data_ok !== 1'b1) begin failures++; $display("FAIL lb_fwd_ok got=%b exp=1", fwd_data_ok); end
    step;
    // stray dm_rvalid while idle must not produce a write
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
    step;
    dm_rvalid = 1'b0;
    checks++; if (rf_we !== 4'b0 || ms_ready !== 1'b1) begin failures++; $display("FAIL idle_rvalid got=%b/%b exp=0000/1", rf_we, ms_ready); end
  endtask

  task automatic test_lwl_lwr;
    drive(3'd5, 2'd1, 5'd3, 1'b1, 32'h0000_3000, 32'd0);
    step;
    ms_valid = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hAABB_CCDD;
    step;
    dm_rvalid = 1'b0;
    checks++; if (rf_we !== 4'b1100) begin failures++; $display("FAIL lwl_rf_we got=%b exp=1100", rf_we); end
    checks++; if (rf_wdata[31:16] !== 16'hCCDD) begin failures++; $display("FAIL lwl_wdata got=%h exp=ccdd", rf_wdata[31:16]); end
    checks++; if (fwd_data_ok !== 1'b0 || fwd_valid !== 1'b1) begin failures++; $display("FAIL lwl_fwd got=%b/%b exp=0/1", fwd_data_ok, fwd_valid); end
    drive(3'd6, 2'd2, 5'd3, 1'b1, 32'h0000_3004, 32'd0);
    step;
    ms_valid = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hAABB_CCDD;
    step;
    dm_rvalid = 1'b0;
    checks++; if (rf_we !== 4'b0011) begin failures++; $display("FAIL lwr_rf_we got=%b exp=0011", rf_we); end
    checks++; if (rf_wdata[15:0] !== 16'hAABB) begin failures++; $display("FAIL lwr_wdata got=%h exp=aabb", rf_wdata[15:0]); end
    checks++; if (fwd_data_ok !== 1'b0) begin failures++; $display("FAIL lwr_fwd_ok got=%b exp=0", fwd_data_ok); end
    step;
  endtask

  task automatic test_no_write;
    drive(3'd7, 2'd0, 5'd0, 1'b1, 32'h0000_4000, 32'h5555_AAAA);
    step;
    drive(3'd7, 2'd0, 5'd9, 1'b0, 32'h0000_4004, 32'h6666_BBBB);
    checks++; if (rf_we !== 4'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL dest0 got=%b/%b exp=0000/0", rf_we, fwd_valid); end
    checks++; if (wb_pc !== 32'h0000_4000) begin failures++; $display("FAIL dest0_pc got=%h exp=00004000", wb_pc); end
    step;
    ms_valid = 1'b0;
    checks++; if (rf_we !== 4'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL nowe got=%b/%b exp=0000/0", rf_we, fwd_valid); end
    checks++; if (wb_pc !== 32'h0000_4004) begin failures++; $display("FAIL nowe_pc got=%h exp=00004004", wb_pc); end
    step;
  endtask

  task automatic test_reset_mid;
    drive(3'd0, 2'd0, 5'd4, 1'b1, 32'h0000_5000, 32'd0);
    step;
    ms_valid = 1'b0;
    checks++; if (fwd_valid !== 1'b1 || ms_ready !== 1'b0) begin failures++; $display("FAIL rw_wait got=%b/%b exp=1/0", fwd_valid, ms_ready); end
    reset = 1'b1;
    step;
    reset = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h7777_8888;
    for (int i = 0; i < 4; i++) begin
      step;
      dm_rvalid = 1'b0;
      checks++; if (rf_we !== 4'b0 || ms_ready !== 1'b1 || fwd_valid !== 1'b0) begin
        failures++; $display("FAIL rw_after cyc=%0d got=%b/%b/%b exp=0000/1/0", i, rf_we, ms_ready, fwd_valid);
      end
    end
    drive(3'd7, 2'd0, 5'd6, 1'b1, 32'h0000_5004, 32'h9999_0000);
    step;
    ms_valid = 1'b0; reset = 1'b1;
    #1;
    checks++; if (rf_we !== 4'b0) begin failures++; $display("FAIL rc_commit got=%b exp=0000", rf_we); end
    step;
    reset = 1'b0;
    step;
    checks++; if (rf_we !== 4'b0) begin failures++; $display("FAIL rc_after got=%b exp=0000", rf_we); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res [4];
    for (int k = 0; k < 4; k++) res[k] = $urandom;
    drive(3'd7, 2'd0, 5'd10, 1'b1, 32'h0000_6000, res[0]);
    for (int k = 0; k < 4; k++) begin
      checks++; if (ms_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, ms_ready); end
      step;
      if (k < 3) drive(3'd7, 2'd0, 5'(11 + k), 1'b1, 32'h0000_6004 + 32'(4 * k), res[k + 1]);
      else ms_valid = 1'b0;
      checks++; if (rf_we !== 4'b1111 || rf_waddr !== 5'(10 + k) || rf_wdata !== res[k]) begin
        failures++; $display("FAIL b2b_commit k=%0d got=%b/%0d/%h exp=1111/%0d/%h", k, rf_we, rf_waddr, rf_wdata, 10 + k, res[k]);
      end
    end
    step;
    checks++; if (rf_we !== 4'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0000", rf_we); end
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [1:0]  a;
    logic [4:0]  dest;
    logic        gwe;
    logic [31:0] pc, res, rd;
    logic [35:0] exp;
    logic        wr;
    int unsigned dly;
    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7)); a = 2'($urandom_range(0, 3));
      dest = 5'($urandom_range(0, 31)); gwe = ($urandom_range(0, 3) != 0);
      pc = $urandom; res = $urandom; rd = $urandom;
      exp = model(op, a, rd, res);
      wr = gwe && (dest != 0);
      drive(op, a, dest, gwe, pc, res);
      checks++; if (ms_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=1", n, ms_ready); end
      step;
      ms_valid = 1'b0;
      if (op != 3'd7) begin
        dly = $urandom_range(0, 3);
        for (int j = 0; j < int'(dly); j++) begin
          dm_rdata = $urandom;
          checks++; if (ms_ready !== 1'b0 || rf_we !== 4'b0 || fwd_valid !== wr) begin
            failures++; $display("FAIL rnd_wait n=%0d got=%b/%b/%b exp=0/0000/%b", n, ms_ready, rf_we, fwd_valid, wr);
          end
          step;
        end
        dm_rvalid = 1'b1; dm_rdata = rd;
        step;
        dm_rvalid = 1'b0; dm_rdata = $urandom;
      end
      checks++; if (rf_we !== (wr ? exp[35:32] : 4'b0)) begin failures++; $display("FAIL rnd_we n=%0d op=%0d a=%0d got=%b exp=%b", n, op, a, rf_we, wr ? exp[35:32] : 4'b0); end
      checks++; if (rf_wdata !== exp[31:0]) begin failures++; $display("FAIL rnd_wdata n=%0d op=%0d a=%0d got=%h exp=%h", n, op, a, rf_wdata, exp[31:0]); end
      checks++; if (rf_waddr !== dest || wb_pc !== pc) begin failures++; $display("FAIL rnd_addr_pc n=%0d got=%0d/%h exp=%0d/%h", n, rf_waddr, wb_pc, dest, pc); end
      checks++; if (fwd_valid !== wr || (wr && fwd_dest !== dest)) begin failures++; $display("FAIL rnd_fwd n=%0d got=%b/%0d exp=%b/%0d", n, fwd_valid, fwd_dest, wr, dest); end
      checks++; if (fwd_data_ok !== (op != 3'd5 && op != 3'd6)) begin failures++; $display("FAIL rnd_fwd_ok n=%0d op=%0d got=%b", n, op, fwd_data_ok); end
      if (op != 3'd5 && op != 3'd6) begin
        checks++; if (fwd_data !== exp[31:0]) begin failures++; $display("FAIL rnd_fwd_data n=%0d got=%h exp=%h", n, fwd_data, exp[31:0]); end
      end
      if ($urandom_range(0, 2) == 0) begin
        step;
        dm_rvalid = 1'b1; dm_rdata = $urandom;
        step;
        dm_rvalid = 1'b0;
        checks++; if (rf_we !== 4'b0 || fwd_valid !== 1'b0 || ms_ready !== 1'b1) begin
          failures++; $display("FAIL rnd_idle n=%0d got=%b/%b/%b exp=0000/0/1", n, rf_we, fwd_valid, ms_ready);
        end
      end
    end
    step;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_lb;
    test_lwl_lwr;
    test_no_write;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
